// File: rtl/ofdm_pkg.sv
// Shared defaults and state encodings for the OFDM cyclic-prefix inserter.
package ofdm_pkg;

    localparam int N_DEF      = 64;
    localparam int CP_LEN_DEF = 16;
    localparam int W_DEF      = 8;

    // Input side: waiting for a start of symbol, or filling a bank
    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    // Output side: no bank ready, emitting the prefix, emitting the body
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CP   = 2'd1,
        R_BODY = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ofdm_cp_bank.sv
// Two-bank symbol store: one synchronous write port and one combinational
// read port, each addressed by a bank bit plus a sample index.
module ofdm_cp_bank
    import ofdm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = 2 * W_DEF,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] bank_rd [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DW-1:0] mem [N];

            // Write the sample into this bank when it is the selected one
            always_ff @(posedge clk) begin
                if (we && (wbank == 1'(gi))) begin
                    mem[waddr] <= wdata;
                end
            end

            assign bank_rd[gi] = mem[raddr];
        end
    endgenerate

    assign rdata = bank_rd[rbank];

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: buffers one IFFT symbol per bank and replays it as
// the last CP_LEN samples followed by all N samples, behind a registered
// output stage with valid/ready handshake.
// Optional feature macro: OFDM_CP_ERR_CNT_EN adds err_clr / err_count, a
// saturating count of frame_err pulses.
module ofdm_cp_inserter
    import ofdm_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int CP_LEN = CP_LEN_DEF,
    parameter int W      = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         in_ready,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    input  logic         out_ready,
    output logic         frame_err
`ifdef OFDM_CP_ERR_CNT_EN
    ,
    input  logic         err_clr,
    output logic [7:0]   err_count
`endif
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);

    wr_state_t       wr_state;
    logic [AW-1:0]   wptr;
    logic            wb;
    rd_state_t       rd_state;
    logic [AW-1:0]   rptr;
    logic            rb;
    logic [1:0]      full;
    logic [1:0]      full_next;

    logic            in_xfer;
    logic            we;
    logic [AW-1:0]   waddr;
    logic            bank_commit;
    logic            wr_err;
    logic            load;
    logic            bank_release;
    logic [2*W-1:0]  rd_data;

    assign in_ready = !full[wb];
    assign in_xfer  = in_valid && in_ready;

    ofdm_cp_bank #(
        .N  (N),
        .DW (2 * W)
    ) u_bank (
        .clk   (clk),
        .we    (we),
        .wbank (wb),
        .waddr (waddr),
        .wdata ({in_re, in_im}),
        .rbank (rb),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Classify each accepted input sample: store, commit the bank, or drop
    always_comb begin
        we          = 1'b0;
        waddr       = wptr;
        bank_commit = 1'b0;
        wr_err      = 1'b0;
        if (in_xfer) begin
            if (in_sop) begin
                // A new start always wins; a partial frame in progress is lost
                we     = 1'b1;
                waddr  = '0;
                wr_err = (wr_state == W_FILL);
            end else if (wr_state == W_FILL) begin
                we = 1'b1;
                if (wptr == LAST_IDX) begin
                    if (in_eop) begin
                        bank_commit = 1'b1;
                    end else begin
                        wr_err = 1'b1;
                    end
                end else if (in_eop) begin
                    wr_err = 1'b1;
                end
            end else begin
                wr_err = 1'b1;
            end
        end
    end

    // Write FSM: tracks fill position, bank selection and the error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= W_IDLE;
            wptr      <= '0;
            wb        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= wr_err;
            if (in_xfer) begin
                if (in_sop) begin
                    wr_state <= W_FILL;
                    wptr     <= AW'(1);
                end else if (wr_state == W_FILL) begin
                    if (in_eop || (wptr == LAST_IDX)) begin
                        wr_state <= W_IDLE;
                        wptr     <= '0;
                    end else begin
                        wptr <= wptr + 1'b1;
                    end
                end
            end
            if (bank_commit) begin
                wb <= ~wb;
            end
        end
    end

    // The reader advances whenever the output register is free or draining
    assign load         = (rd_state != R_IDLE) && (!out_valid || out_ready);
    assign bank_release = load && (rd_state == R_BODY) && (rptr == LAST_IDX);

    // Commit and release never target the same bank, so both apply at once
    always_comb begin
        full_next = full;
        if (bank_commit) begin
            full_next[wb] = 1'b1;
        end
        if (bank_release) begin
            full_next[rb] = 1'b0;
        end
    end

    // Per-bank occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    // Read FSM plus the registered output stage it feeds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            rptr      <= '0;
            rb        <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            if (load) begin
                out_valid        <= 1'b1;
                {out_re, out_im} <= rd_data;
                out_sop          <= (rd_state == R_CP) && (rptr == CP_START);
                out_eop          <= bank_release;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end

            case (rd_state)
                R_IDLE: begin
                    if (full[rb]) begin
                        rd_state <= R_CP;
                        rptr     <= CP_START;
                    end
                end
                R_CP: begin
                    if (load) begin
                        if (rptr == LAST_IDX) begin
                            rd_state <= R_BODY;
                            rptr     <= '0;
                        end else begin
                            rptr <= rptr + 1'b1;
                        end
                    end
                end
                R_BODY: begin
                    if (load) begin
                        if (rptr == LAST_IDX) begin
                            rb <= ~rb;
                            // Chain straight into the other bank to avoid a gap
                            if (full_next[~rb]) begin
                                rd_state <= R_CP;
                                rptr     <= CP_START;
                            end else begin
                                rd_state <= R_IDLE;
                                rptr     <= '0;
                            end
                        end else begin
                            rptr <= rptr + 1'b1;
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                    rptr     <= '0;
                end
            endcase
        end
    end

`ifdef OFDM_CP_ERR_CNT_EN
    // Saturating frame_err counter; a clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= 8'd0;
        end else if (frame_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Self-checking bench for ofdm_cp_inserter: frame-level reference model with
// an expected-output queue, table-driven frame scenarios, hand-written
// latency / back-to-back / reset / counter sequences, and randomized traffic.
module tb_ofdm_cp_inserter;

    localparam int N  = 64;
    localparam int CP = 16;

    localparam int K_GOOD  = 0;
    localparam int K_EOP40 = 1;
    localparam int K_SOP30 = 2;
    localparam int K_NOEOP = 3;
    localparam int K_STRAY = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sop, in_eop;
    logic [7:0] in_re, in_im;
    logic       in_ready;
    logic       out_valid, out_sop, out_eop;
    logic [7:0] out_re, out_im;
    logic       out_ready;
    logic       frame_err;
`ifdef OFDM_CP_ERR_CNT_EN
    logic       err_clr;
    logic [7:0] err_count;
`endif

    ofdm_cp_inserter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_ready (out_ready),
        .frame_err (frame_err)
`ifdef OFDM_CP_ERR_CNT_EN
        ,
        .err_clr   (err_clr),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] cur [$];
    bit          in_frame;
    logic [17:0] exp_q [$];
    int          exp_errs = 0;
    int          commits = 0;
    int          err_seen = 0;
    int          out_frames = 0;
    int          out_xfers = 0;
    int          bp_cnt = 0;
    int          in_eop_cyc = 0;
    int          first_valid_cyc = 0;
    int          sop_q [$];

    int rmode = 0;
    int gap_max = 0;

    typedef struct {
        string name;
        int    kind;
        int    rmode;
        int    gapmax;
        int    exp_frames;
        int    exp_errs;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Spec-level framing rules applied to each accepted input sample
    task automatic model_in(input bit s, input bit e, input logic [15:0] d);
        if (e) in_eop_cyc = cyc + 1;
        if (s) begin
            if (in_frame) exp_errs++;
            cur.delete();
            cur.push_back(d);
            in_frame = 1'b1;
        end else if (!in_frame) begin
            exp_errs++;
        end else begin
            cur.push_back(d);
            if (e || cur.size() == N) begin
                if (e && cur.size() == N) begin
                    commits++;
                    for (int i = N - CP; i < N; i++) exp_q.push_back({(i == N - CP), 1'b0, cur[i]});
                    for (int i = 0; i < N; i++) exp_q.push_back({1'b0, (i == N - 1), cur[i]});
                end else begin
                    exp_errs++;
                end
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        bit          prev_stall = 1'b0;
        bit          prev_valid = 1'b0;
        logic [17:0] prev_out = '0;
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                cur.delete();
                in_frame   = 1'b0;
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {out_valid, out_sop, out_eop, out_re, out_im}, {1'b1, prev_out});
                if (out_valid && !prev_valid) first_valid_cyc = cyc;
                if (frame_err) err_seen++;
                if (in_valid && !in_ready) bp_cnt++;
                if (in_valid && in_ready) model_in(in_sop, in_eop, {in_re, in_im});
                if (out_valid && out_ready) begin
                    out_xfers++;
                    if (out_sop) sop_q.push_back(cyc + 1);
                    if (out_eop) out_frames++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_sample", {out_sop, out_eop, out_re, out_im}, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_sop, out_eop, out_re, out_im};
                prev_valid = out_valid;
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input bit s, input bit e, input logic [7:0] r, input logic [7:0] i);
        int n = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        in_re    = r;
        in_im    = i;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 3000) begin
                    check("in_ready_timeout", 32'd0, 32'd1);
                    @(posedge clk);
                    #1;
                    done = 1'b1;
                end
            end
        end
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic send_run(input int len, input int eop_at);
        for (int k = 0; k < len; k++)
            send_sample(k == 0, k == eop_at, 8'($urandom), 8'($urandom));
    endtask

    task automatic send_kind(input int kind);
        case (kind)
            K_EOP40: send_run(41, 40);
            K_SOP30: send_run(30, -1);
            K_NOEOP: send_run(N, -1);
            K_STRAY: send_sample(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            default: ;
        endcase
        send_run(N, N - 1);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        rmode = 0;
        idle(4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sop"}, 32'(out_sop), 32'd0);
        check({tag, "_out_eop"}, 32'(out_eop), 32'd0);
        check({tag, "_out_re"}, 32'(out_re), 32'd0);
        check({tag, "_out_im"}, 32'(out_im), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int f0, e0, c0, x0, b0, s0, n;

        tbl[0] = '{"good_ready1",   K_GOOD,  0, 0, 1, 0};
        tbl[1] = '{"good_toggle",   K_GOOD,  1, 0, 1, 0};
        tbl[2] = '{"eop40",         K_EOP40, 0, 0, 1, 1};
        tbl[3] = '{"sop30",         K_SOP30, 0, 0, 1, 1};
        tbl[4] = '{"no_eop",        K_NOEOP, 0, 0, 1, 1};
        tbl[5] = '{"stray_toggle",  K_STRAY, 1, 0, 1, 1};
        tbl[6] = '{"eop40_random",  K_EOP40, 2, 2, 1, 1};
        tbl[7] = '{"sop30_random",  K_SOP30, 2, 2, 1, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
`ifdef OFDM_CP_ERR_CNT_EN
        err_clr   = 1'b0;
`endif
        fork
            monitor();
            ready_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef OFDM_CP_ERR_CNT_EN
        check("reset_err_count", 32'(err_count), 32'd0);
`endif

        // Single ramp symbol: re=k, im=-k, free-flowing output
        f0 = out_frames;
        for (int k = 0; k < N; k++)
            send_sample(k == 0, k == N - 1, 8'(k), 8'(0 - k));
        drain();
        check("single_latency", 32'(first_valid_cyc - in_eop_cyc), 32'd2);
        check("single_frames", 32'(out_frames - f0), 32'd1);
        $display("txn single_symbol frames=%0d latency=%0d", out_frames - f0, first_valid_cyc - in_eop_cyc);

        // Table of frame scenarios, each ending in one well-formed symbol
        for (int t = 0; t < 8; t++) begin
            f0 = out_frames;
            e0 = err_seen;
            rmode   = tbl[t].rmode;
            gap_max = tbl[t].gapmax;
            send_kind(tbl[t].kind);
            gap_max = 0;
            drain();
            check({tbl[t].name, "_frames"}, 32'(out_frames - f0), 32'(tbl[t].exp_frames));
            check({tbl[t].name, "_frame_err"}, 32'(err_seen - e0), 32'(tbl[t].exp_errs));
            $display("txn %s frames=%0d frame_err=%0d", tbl[t].name, out_frames - f0, err_seen - e0);
        end

        // Four symbols back to back with in_valid held high
        b0 = bp_cnt;
        x0 = out_xfers;
        s0 = sop_q.size();
        for (int s = 0; s < 4; s++) send_run(N, N - 1);
        drain();
        check("b2b_backpressure", 32'(bp_cnt > b0), 32'd1);
        check("b2b_xfers", 32'(out_xfers - x0), 32'(4 * (N + CP)));
        check("b2b_sops", 32'(sop_q.size() - s0), 32'd4);
        if (sop_q.size() - s0 == 4)
            for (int k = 0; k < 3; k++)
                check("b2b_spacing", 32'(sop_q[s0 + k + 1] - sop_q[s0 + k]), 32'(N + CP));
        $display("txn back_to_back xfers=%0d stalls=%0d", out_xfers - x0, bp_cnt - b0);

        // Reset while a frame is being emitted
        x0 = out_xfers;
        send_run(N, N - 1);
        idle(0);
        n = 0;
        while (out_xfers < x0 + 10 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_output_reached", 32'(n < 500), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_output");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("post_rst_idle", 32'(out_valid), 32'd0);
        $display("txn reset_mid_output out_valid=%0d", out_valid);

        // Reset while a frame is half written, then a clean symbol
        f0 = out_frames;
        e0 = err_seen;
        send_run(20, -1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        send_run(N, N - 1);
        drain();
        check("rst_partial_frames", 32'(out_frames - f0), 32'd1);
        check("rst_partial_err", 32'(err_seen - e0), 32'd0);
        $display("txn reset_partial frames=%0d frame_err=%0d", out_frames - f0, err_seen - e0);

        // Randomized traffic against the reference model
        f0 = out_frames;
        e0 = err_seen;
        c0 = commits;
        b0 = exp_errs;
        rmode   = 2;
        gap_max = 3;
        for (int s = 0; s < 30; s++) send_kind($urandom_range(0, 4));
        gap_max = 0;
        drain();
        check("random_frames", 32'(out_frames - f0), 32'(commits - c0));
        check("random_frame_err", 32'(err_seen - e0), 32'(exp_errs - b0));
        $display("txn random frames=%0d frame_err=%0d", out_frames - f0, err_seen - e0);

`ifdef OFDM_CP_ERR_CNT_EN
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
        check("cnt_cleared", 32'(err_count), 32'd0);
        for (int k = 0; k < 10; k++) send_sample(1'b0, 1'b0, 8'd1, 8'd2);
        idle(3);
        check("cnt_ten", 32'(err_count), 32'd10);
        for (int k = 0; k < 290; k++) send_sample(1'b0, 1'b0, 8'd1, 8'd2);
        idle(3);
        check("cnt_saturate", 32'(err_count), 32'd255);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
        check("cnt_clr", 32'(err_count), 32'd0);
        send_sample(1'b0, 1'b0, 8'd1, 8'd2);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(2);
        check("cnt_clr_priority", 32'(err_count), 32'd0);
        $display("txn err_count final=%0d", err_count);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
